edge_event_unit: RTL and testbench

Multi-channel, parametrised edge detector for the I2C/AXI peripheral. It synchronises asynchronous pin-level inputs (SCL, SDA, external events) and deglitches them with a programmable stable-count filter. It then produces per-channel single-cycle edge pulses for the modes rising, falling or both. Sticky write-1-to-clear status and a level interrupt sit behind it for the register block.

---
 rtl/edge_event_unit.sv | 128 ++++++++++++
 tb/tb_edge_event_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_unit.sv
// edge_event_unit: per-channel sync -> stable-count filter -> edge pulses,
// sticky W1C status and registered irq. Optional sync chain: EDGE_EVENT_SYNC_EN.
// Ports: clk, reset_n (async low), sig_in, mode[2i+1:2i] (00 off/01 rise/
// 10 fall/11 both), filter_cycles, clear -> filt_out, edge_pulse, edge_rise,
// edge_fall, status, irq.
module edge_event_unit #(
  parameter int   CHANNELS    = 4,
  parameter int   FILTER_W    = 4,
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT_LEVEL  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   sig_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [FILTER_W-1:0]   filter_cycles,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   filt_out,
  output logic [CHANNELS-1:0]   edge_pulse,
  output logic [CHANNELS-1:0]   edge_rise,
  output logic [CHANNELS-1:0]   edge_fall,
  output logic [CHANNELS-1:0]   status,
  output logic                  irq
);

  logic [CHANNELS-1:0] sync_lvl;

`ifdef EDGE_EVENT_SYNC_EN
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = sig_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= {CHANNELS{INIT_LEVEL}};
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];
`else
  logic unused_sync_stages;
  assign unused_sync_stages = ^SYNC_STAGES;
  assign sync_lvl = sig_in;
`endif

  logic [FILTER_W-1:0] cnt_q [CHANNELS];
  logic [FILTER_W-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0] filt_q, filt_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] pulse_q, pulse_d;
  logic [CHANNELS-1:0] status_q, status_d;
  logic                irq_q, irq_d;
  logic [CHANNELS-1:0] mode_rise, mode_fall;

  always_comb begin
    mode_rise = '0;
    mode_fall = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      mode_rise[i] = mode[2*i];
      mode_fall[i] = mode[2*i+1];
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync_lvl[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= filter_cycles) begin
        // >= so a lowered filter_cycles accepts at once
        filt_d[i] = sync_lvl[i];
        cnt_d[i]  = '0;
        rise_d[i] = sync_lvl[i];
        fall_d[i] = ~sync_lvl[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    pulse_d  = (rise_d & mode_rise) | (fall_d & mode_fall);
    // set beats a simultaneous clear
    status_d = (status_q & ~clear) | pulse_d;
    irq_d    = |status_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      filt_q   <= {CHANNELS{INIT_LEVEL}};
      rise_q   <= '0;
      fall_q   <= '0;
      pulse_q  <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      filt_q   <= filt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pulse_q  <= pulse_d;
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

  assign filt_out   = filt_q;
  assign edge_rise  = rise_q;
  assign edge_fall  = fall_q;
  assign edge_pulse = pulse_q;
  assign status     = status_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_edge_event_unit.sv
// tb_edge_event_unit: scoreboard bench for edge_event_unit.
// Window-based reference model, directed plan sequences plus random traffic.
module tb_edge_event_unit;
  localparam int   CH   = 4;
  localparam int   FW   = 4;
  localparam logic INIT = 1'b1;
`ifdef EDGE_EVENT_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  typedef struct packed {
    logic [CH-1:0] filt;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] pulse;
    logic [CH-1:0] status;
    logic          irq;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] sig_in;
  logic [2*CH-1:0] mode;
  logic [FW-1:0] filter_cycles;
  logic [CH-1:0] clear;
  logic [CH-1:0] filt_out, edge_pulse, edge_rise, edge_fall, status;
  logic          irq;

  edge_event_unit dut (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .mode(mode),
    .filter_cycles(filter_cycles), .clear(clear), .filt_out(filt_out),
    .edge_pulse(edge_pulse), .edge_rise(edge_rise), .edge_fall(edge_fall),
    .status(status), .irq(irq)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  exp_t          sbq[$];
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_filt;
  logic [CH-1:0] m_status;
  int            last_acc[CH];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // level the filter sees at edge t (t counts edges since reset release)
  function automatic logic smp(input int t, input int ch);
    int idx;
    idx = t - S;
    if (idx < 0) return INIT;
    return hist[idx][ch];
  endfunction

  task automatic model_reset();
    hist.delete();
    m_filt   = {CH{INIT}};
    m_status = '0;
    for (int c = 0; c < CH; c++) last_acc[c] = -1;
  endtask

  // accept at edge t when the last N+1 samples since the previous accept
  // all disagree with the held level
  task automatic step(input logic [CH-1:0] s, input logic [2*CH-1:0] m,
                      input logic [CH-1:0] c, input logic [FW-1:0] n);
    exp_t e;
    int   t, run, k;
    logic v;
    @(negedge clk);
    #1;
    sig_in = s;
    mode = m;
    clear = c;
    filter_cycles = n;
    hist.push_back(s);
    t = hist.size() - 1;
    e = '0;
    e.irq = |m_status;
    for (int ch = 0; ch < CH; ch++) begin
      v = smp(t, ch);
      if (v != m_filt[ch]) begin
        run = 0;
        k = t;
        while (k > last_acc[ch] && run <= int'(n) && smp(k, ch) != m_filt[ch]) begin
          run++;
          k--;
        end
        if (run >= int'(n) + 1) begin
          e.rise[ch]   = v;
          e.fall[ch]   = ~v;
          e.pulse[ch]  = v ? m[2*ch] : m[2*ch+1];
          m_filt[ch]   = v;
          last_acc[ch] = t;
        end
      end
    end
    m_status = (m_status & ~c) | e.pulse;
    e.status = m_status;
    e.filt   = m_filt;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("filt_out", 32'(filt_out), 32'(e.filt));
      chk("edge_rise", 32'(edge_rise), 32'(e.rise));
      chk("edge_fall", 32'(edge_fall), 32'(e.fall));
      chk("edge_pulse", 32'(edge_pulse), 32'(e.pulse));
      chk("status", 32'(status), 32'(e.status));
      chk("irq", 32'(irq), 32'(e.irq));
    end
  end

  task automatic idle(input int cyc, input logic [CH-1:0] s,
                      input logic [2*CH-1:0] m, input logic [FW-1:0] n);
    for (int j = 0; j < cyc; j++) step(s, m, '0, n);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_filt"}, 32'(filt_out), 32'({CH{INIT}}));
    chk({tag, "_edges"}, 32'({edge_rise, edge_fall, edge_pulse}), 32'(0));
    chk({tag, "_status"}, 32'(status), 32'(0));
    chk({tag, "_irq"}, 32'(irq), 32'(0));
  endtask

  logic [CH-1:0]   cur;
  logic [2*CH-1:0] rmode;
  logic [FW-1:0]   rn;
  logic [CH-1:0]   rclr;

  initial begin
    reset_n = 1'b0;
    sig_in = '1;
    mode = '0;
    filter_cycles = '0;
    clear = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("rst");
    #1;
    reset_n = 1'b1;

    // idle high lines: nothing happens
    idle(20, 4'hF, 8'h00, 4'd0);

    // ch0 rise-only, N=0: fall then rise
    idle(6, 4'hE, 8'h01, 4'd0);
    idle(6, 4'hF, 8'h01, 4'd0);

    // ch1 both, N=3: 3-cycle glitch, then 4-cycle low
    idle(3, 4'hD, 8'h0D, 4'd3);
    idle(8, 4'hF, 8'h0D, 4'd3);
    idle(4, 4'hD, 8'h0D, 4'd3);
    idle(10, 4'hF, 8'h0D, 4'd3);

    // clear in the accept cycle of a new pulse, then clear alone
    idle(6, 4'hE, 8'h01, 4'd0);
    for (int j = 0; j < 6; j++)
      step(4'hF, 8'h01, (j == S) ? 4'h1 : 4'h0, 4'd0);
    idle(3, 4'hF, 8'h01, 4'd0);
    step(4'hF, 8'h01, 4'hF, 4'd0);
    idle(4, 4'hF, 8'h01, 4'd0);

    // ch2 off, ch3 both, simultaneous toggles
    idle(6, 4'h3, 8'hC0, 4'd0);
    idle(6, 4'hF, 8'hC0, 4'd0);

    // async reset while ch0 change is pending with N=7
    idle(4, 4'hE, 8'hFF, 4'd7);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("arst");
    sig_in = '1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    idle(20, 4'hF, 8'hFF, 4'd7);

    // random traffic
    cur = 4'hF;
    rmode = 8'hFF;
    rn = 4'd1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 150 == 0) rn = FW'($urandom_range(0, 5));
      if (cyc % 100 == 0) rmode = 8'($urandom);
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 4) == 0) cur[c] = ~cur[c];
      rclr = '0;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 7) == 0) rclr[c] = 1'b1;
      step(cur, rmode, rclr, rn);
    end
    idle(4, cur, rmode, rn);

    @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(sbq.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
